// File: rtl/chronos_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chronos_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_grant.sv
// Grant select between fetch and data, with a starvation counter for fetch.
// Latency: combinational grant_if; the counter updates on the grant edge.
// Backpressure: none; only acts when grant_en is high (arbiter idle with a request).
// Ports: clk, rst (sync, active-low), if_req, d_req, grant_en -> grant_if.
module arb_grant
    import chronos_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_if
);

    // One bit minimum so MAX_STARVE = 0 still gives a legal counter.
    localparam int CW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

    logic [CW-1:0] starve_cnt;

    // Data wins a tie unless fetch has been passed over MAX_STARVE times.
    assign grant_if = if_req && (!d_req || (starve_cnt == CNT_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (grant_if) begin
                starve_cnt <= '0;
            end else if (if_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (D), one transaction at a time.
// Latency: request at edge N -> mem_req in cycle N+1 -> valid no earlier than N+2; 3-cycle peak.
// Backpressure: requests are held until their valid pulse; the memory stalls via late mem_valid.
// Ports: clk, rst (sync, active-low); if_req/if_addr -> if_rdata/if_valid;
//        d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid; mem_req/mem_we/mem_addr/mem_wdata,
//        mem_rdata/mem_valid; err (abort flag).
// Optional: define CHRONOS_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with err=1.
module mem_arbiter
    import chronos_arb_pkg::*;
#(
    parameter int AW         = XLEN,
    parameter int DW         = XLEN,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          err
);

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          mem_req_q;
    logic          if_valid_q, d_valid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;
    logic          grant_en, grant_if;
    logic          load_resp;
    logic [DW-1:0] resp_data;

`ifdef CHRONOS_ARB_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    // Abort on the edge where the count would reach TIMEOUT, giving exactly TIMEOUT WAIT cycles.
    localparam logic [WCW-1:0] TO_LAST = WCW'(TIMEOUT - 1);
    logic [WCW-1:0] wait_cnt;
    logic           abort;
    logic           err_q;
`endif

    arb_grant #(
        .MAX_STARVE (MAX_STARVE)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_if (grant_if)
    );

    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        load_resp = 1'b0;
        resp_data = mem_rdata;
`ifdef CHRONOS_ARB_TIMEOUT_EN
        abort     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                load_resp = mem_valid;
                state_d   = mem_valid ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    load_resp = 1'b1;
                    state_d   = RESP;
                end
`ifdef CHRONOS_ARB_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    abort     = 1'b1;
                    load_resp = 1'b1;
                    resp_data = '0;
                    state_d   = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are flops loaded from the next state, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= (state_d == ISSUE);
            if_valid_q <= (state_d == RESP) && (owner_q == OWN_IF);
            d_valid_q  <= (state_d == RESP) && (owner_q == OWN_D);
            if (grant_en) begin
                owner_q <= grant_if ? OWN_IF : OWN_D;
                addr_q  <= grant_if ? if_addr : d_addr;
                we_q    <= grant_if ? 1'b0 : d_we;
                wdata_q <= grant_if ? '0 : d_wdata;
            end
            // Only the owner's rdata moves; the other side keeps its last value.
            if (load_resp) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= resp_data;
                end else begin
                    d_rdata_q <= resp_data;
                end
            end
        end
    end

`ifdef CHRONOS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= abort;
            if (state_q == ISSUE) begin
                wait_cnt <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
